// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register-write scoreboard for an in-order pipeline without RF bypass.
//   Tracks, per architectural register, how many issued writes have not yet
//   reached writeback, stalls decode on RAW hazards or counter saturation,
//   and sequences HALT through a drain phase before stopping.
//
// Ports
//   clk                     sole clock, rising edge
//   rst                     synchronous active-low reset
//   id_valid                decode holds a valid instruction
//   id_rs_sel / id_rt_sel   source register selects
//   id_rs_used / id_rt_used source actually read
//   id_rd_sel, id_regwrite  destination register and write enable
//   id_halt                 decode instruction is HALT
//   flush                   decode instruction is squashed
//   wb_regwrite, wb_regsel  register-file write in writeback this cycle
//   stall                   hold PC and IF/ID
//   issue                   decode instruction advances into ID/EX
//   bubble                  insert NOP into ID/EX
//   halted                  pipeline drained and stopped
//   sb_err                  sticky counter-underflow flag
module hazard_scoreboard #(
  parameter int MAXINF = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_rs_sel,
  input  logic [2:0] id_rt_sel,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] id_rd_sel,
  input  logic       id_regwrite,
  input  logic       id_halt,
  input  logic       flush,
  input  logic       wb_regwrite,
  input  logic [2:0] wb_regsel,
  output logic       stall,
  output logic       issue,
  output logic       bubble,
  output logic       halted,
  output logic       sb_err
);

  localparam int NREG = 8;
  localparam int CW   = $clog2(MAXINF + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAXINF);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]              state_q, state_d;
  logic                    err_q, err_d;
  logic                    hazard, run, uflow;

  // Hazards are judged purely on registered counts: a writeback in the same
  // cycle does not clear a RAW hazard because the register file cannot bypass.
  assign hazard = (id_rs_used  && (cnt_q[id_rs_sel] != '0))
               || (id_rt_used  && (cnt_q[id_rt_sel] != '0))
               || (id_regwrite && (cnt_q[id_rd_sel] == CMAX));

  assign run    = (state_q == S_RUN);
  assign issue  = run && id_valid && !flush && !hazard;
  assign stall  = run ? (id_valid && !flush && hazard) : 1'b1;
  assign bubble = !issue;
  assign halted = (state_q == S_HALTED);
  assign sb_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    uflow = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = issue && id_regwrite && (id_rd_sel == 3'(r));
      dec = wb_regwrite && (wb_regsel == 3'(r));
      // Simultaneous inc/dec on one register cancel out; no underflow then.
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) uflow = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  assign err_d = err_q | uflow;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (issue && id_halt) state_d = S_DRAIN;
      // Drain completes on the post-update counter values of this cycle.
      S_DRAIN:  if (cnt_d == '0)      state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      state_q <= S_RUN;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule
